// File: rtl/cam_alloc_ctrl.sv
// Write-side allocator for the CAM: buffers write requests, places each one in the lowest
// free CAM line, and frees lines on consumer hit pops. Optional stall statistics: CAM_ALLOC_STATS_EN.
module cam_alloc_ctrl #(
  parameter int CAM_DW  = 32,
  parameter int CAM_AW  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CAM_DW-1:0] req_data,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CAM_DW-1:0] cam_data_in,
  output logic [CAM_AW-1:0] cam_addr_in,
  output logic              cam_input_valid,
  input  logic              cam_hit,
  input  logic [CAM_AW-1:0] cam_addr_out,
  input  logic              cam_data_valid,
  output logic [CAM_AW:0]   free_cnt,
  output logic              cam_full,
  output logic [15:0]       stall_cnt
);

  localparam int NLINES = 1 << CAM_AW;
  localparam int FDEPTH = 1 << FIFO_AW;

  logic [CAM_DW-1:0] fifo_mem [FDEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr, fifo_cnt;
  logic              fifo_empty, do_push;

  logic [NLINES-1:0] occ;
  logic [CAM_AW-1:0] free_idx;
  logic              any_free, do_issue, do_release;

  // Count fits in FIFO_AW+1 bits, so its MSB is set exactly when the FIFO holds FDEPTH entries.
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_cnt == '0);
  assign req_ready  = ~fifo_cnt[FIFO_AW];
  assign do_push    = req_valid & req_ready;

  // Lowest-indexed free line; scanning downward lets the smallest index win.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_idx = CAM_AW'(i);
        any_free = 1'b1;
      end
    end
  end

  // Issue reads only the registered map, so a line freed this cycle is not reused until the next.
  assign do_issue   = ~fifo_empty & any_free;
  assign do_release = cam_hit & cam_data_valid & occ[cam_addr_out];

  // NOTE: the request storage is deliberately not reset; entries are only read once the
  // reset pointers say they were written, so clearing them would add fanout for nothing.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= req_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      free_cnt        <= (CAM_AW+1)'(NLINES);
      cam_input_valid <= 1'b0;
      cam_data_in     <= '0;
      cam_addr_in     <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      cam_input_valid <= do_issue;
      if (do_issue) begin
        rd_ptr        <= rd_ptr + 1'b1;
        cam_data_in   <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
        cam_addr_in   <= free_idx;
        occ[free_idx] <= 1'b1;
      end
      // A release always targets an occupied line and an issue a free one, so they never collide.
      if (do_release) occ[cam_addr_out] <= 1'b0;
      free_cnt <= free_cnt - {{CAM_AW{1'b0}}, do_issue} + {{CAM_AW{1'b0}}, do_release};
    end
  end

  assign cam_full = (free_cnt == '0);

`ifdef CAM_ALLOC_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!fifo_empty && cam_full && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Self-checking bench for cam_alloc_ctrl with a 4-line CAM: a queue/array reference model
// predicts each cycle's CAM write, and a separate monitor pops and compares the predictions.
module tb_cam_alloc_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 2;
  localparam int FAW    = 2;
  localparam int NL     = 1 << AW;
  localparam int FDEPTH = 1 << FAW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] req_data;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] cam_data_in;
  logic [AW-1:0] cam_addr_in;
  logic          cam_input_valid;
  logic          cam_hit;
  logic [AW-1:0] cam_addr_out;
  logic          cam_data_valid;
  logic [AW:0]   free_cnt;
  logic          cam_full;
  logic [15:0]   stall_cnt;

  cam_alloc_ctrl #(.CAM_DW(DW), .CAM_AW(AW), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .cam_data_in(cam_data_in), .cam_addr_in(cam_addr_in), .cam_input_valid(cam_input_valid),
    .cam_hit(cam_hit), .cam_addr_out(cam_addr_out), .cam_data_valid(cam_data_valid),
    .free_cnt(free_cnt), .cam_full(cam_full), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  int            tests = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  exp_t          sb[$];
  logic [DW-1:0] m_fifo[$];
  bit            m_occ[NL];
  int            m_stall;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < NL; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    sb.delete();
    for (int i = 0; i < NL; i++) m_occ[i] = 1'b0;
    m_stall = 0;
    m_data  = '0;
    m_addr  = '0;
  endtask

  function automatic int exp_stall();
`ifdef CAM_ALLOC_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic check_state();
    check("req_ready", req_ready, m_fifo.size() < FDEPTH);
    check("free_cnt", free_cnt, m_free());
    check("cam_full", cam_full, m_free() == 0);
    check("stall_cnt", stall_cnt, exp_stall());
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", req_ready, 1);
    check("rst_input_valid", cam_input_valid, 0);
    check("rst_data_in", cam_data_in, 0);
    check("rst_addr_in", cam_addr_in, 0);
    check("rst_free_cnt", free_cnt, NL);
    check("rst_cam_full", cam_full, 0);
    check("rst_stall_cnt", stall_cnt, 0);
  endtask

  // Drive one cycle of inputs, predict what the next edge does, then wait until after it.
  task automatic step(input logic rv, input logic [DW-1:0] d, input logic hit,
                      input logic dv, input logic [AW-1:0] ao);
    bit   acc, iss, rel;
    int   idx;
    exp_t e;
    req_valid = rv; req_data = d; cam_hit = hit; cam_data_valid = dv; cam_addr_out = ao;
    acc = rv && (m_fifo.size() < FDEPTH);
    idx = -1;
    for (int i = NL - 1; i >= 0; i--) if (!m_occ[i]) idx = i;
    iss = (m_fifo.size() > 0) && (idx >= 0);
    rel = hit && dv && m_occ[ao];
    if (m_fifo.size() > 0 && m_free() == 0 && m_stall < 65535) m_stall++;
    if (iss) begin
      m_data = m_fifo.pop_front();
      m_addr = AW'(idx);
    end
    e.v = iss; e.a = m_addr; e.d = m_data;
    sb.push_back(e);
    if (rel) m_occ[ao] = 1'b0;
    if (iss) m_occ[idx] = 1'b1;
    if (acc) m_fifo.push_back(d);
    @(negedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic req(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic pop(input logic hit, input logic [AW-1:0] a);
    step(1'b0, '0, hit, 1'b1, a);
  endtask

  // Monitor: compares the CAM write port against the oldest prediction each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("cam_input_valid", cam_input_valid, e.v);
          check("cam_addr_in", cam_addr_in, e.a);
          check("cam_data_in", cam_data_in, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0;
    cam_hit = 1'b0; cam_addr_out = '0; cam_data_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Back-to-back requests land on lines 0, 1, 2 in consecutive cycles.
    req(32'hA); req(32'hB); req(32'hC);
    idle(3);
    check("free_after_abc", free_cnt, 1);

    // Fill the last line, then stall with two requests waiting.
    req(32'hD); req(32'hE); req(32'hF);
    idle(4);
    check("full_after_6", cam_full, 1);

    // Release line 2: the next waiting request lands there one cycle later.
    pop(1'b1, 2'd2);
    idle(1);
    check("free_back_to_0", free_cnt, 0);

    // Free line 1, then release line 0 in the same cycle line 1 is issued.
    req(32'h10); req(32'h11);
    pop(1'b1, 2'd1);
    pop(1'b1, 2'd0);
    check("same_cycle_free", free_cnt, 1);
    idle(1);

    // Ignored releases: no hit, then a repeat release of an already-freed line.
    pop(1'b0, 2'd3);
    check("nohit_free", free_cnt, 0);
    pop(1'b1, 2'd3);
    pop(1'b1, 2'd3);
    idle(2);

    // CAM full: four requests fill the FIFO and the fifth sees req_ready low.
    check("full_before_fifo", cam_full, 1);
    for (int i = 0; i < 5; i++) req(32'h20 + i);
    check("fifo_full_ready", req_ready, 0);

    // Asynchronous reset mid-stream.
    step(1'b1, 32'h99, 1'b0, 1'b0, '0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Randomised traffic with random hit pops.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 45, AW'($urandom_range(0, NL - 1)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
